stack_lifo: RTL and testbench

Parametrised hardware LIFO stack with an internal stack pointer, push/pop/replace operations, full/empty status and sticky overflow/underflow error flags. Successor to the externally-addressed 8-bit stack memory: callers no longer manage addresses. It sits beside the PBL CPU control unit as the call/return and data stack, and its top-of-stack output can drive the existing BCD-to-7-segment display path directly.

---
 rtl/stack_lifo_pkg.sv | 22 ++
 rtl/stack_lifo_mem.sv | 37 +++
 rtl/stack_lifo.sv | 140 ++++++++++++++
 tb/tb_stack_lifo.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/stack_lifo_pkg.sv
// ---------------------------------------------------------------------------
// pbl_stack_pkg
// Shared definitions for the LIFO stack block.
//   op_e      : per-cycle operation decoded from {push, pop}
//   cnt_width : width of an occupancy counter able to hold 0..depth
// ---------------------------------------------------------------------------
package pbl_stack_pkg;

    typedef enum logic [1:0] {
        OP_IDLE    = 2'b00,
        OP_POP     = 2'b01,
        OP_PUSH    = 2'b10,
        OP_REPLACE = 2'b11
    } op_e;

    // A counter that must represent "completely full" needs one more code
    // than there are entries, hence depth+1.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/stack_lifo_mem.sv
// ---------------------------------------------------------------------------
// stack_mem
// WIDTH x DEPTH register file backing the LIFO stack.
// Ports:
//   clk    in   rising-edge clock for the write port
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   asynchronous read address
//   rdata  out  asynchronous read data (zero for addresses >= DEPTH)
// Storage carries no reset; validity is tracked by the owner's counter.
// ---------------------------------------------------------------------------
module stack_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // DEPTH need not be a power of two, so some address codes are unmapped.
    assign rdata = (int'(raddr) < DEPTH) ? r_mem[raddr] : '0;

endmodule

// File: rtl/stack_lifo.sv
// ---------------------------------------------------------------------------
// stack_lifo
// Parametrised LIFO stack with internal stack pointer, push/pop/replace,
// full/empty status and sticky overflow/underflow flags.
// Ports:
//   clk        in   clock, all state updates on rising edge
//   rst        in   synchronous active-high reset
//   push       in   push din this cycle
//   pop        in   pop top entry this cycle (push+pop = replace top)
//   din        in   data to push / replace
//   clr        in   synchronous flush of count and error flags
//   tos        out  top-of-stack value (zero when empty)
//   count      out  number of valid entries, 0..DEPTH
//   empty      out  count == 0
//   full       out  count == DEPTH
//   overflow   out  sticky: a push was rejected while full
//   underflow  out  sticky: a pop was rejected while empty
// ---------------------------------------------------------------------------
module stack_lifo
    import pbl_stack_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32,
    parameter int CW    = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    input  logic             clr,
    output logic [WIDTH-1:0] tos,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = $clog2(DEPTH);

    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic             r_underflow;

    op_e              w_op;
    logic             w_empty;
    logic             w_full;
    logic             w_flush;
    logic             w_we;
    logic [AW-1:0]    w_waddr;
    logic [AW-1:0]    w_raddr;
    logic [WIDTH-1:0] w_rdata;

    assign w_op    = op_e'({push, pop});
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_flush = rst | clr;

    // The counter doubles as the write pointer; the top entry sits one below.
    assign w_raddr = AW'(r_count - CW'(1));

    always_comb begin
        w_we    = 1'b0;
        w_waddr = AW'(r_count);
        case (w_op)
            OP_PUSH: begin
                w_we = ~w_full;
            end
            OP_REPLACE: begin
                // On an empty stack replace degenerates to a push into slot 0,
                // which is exactly what the default address already gives.
                w_we = 1'b1;
                if (!w_empty) begin
                    w_waddr = w_raddr;
                end
            end
            default: begin
                w_we = 1'b0;
            end
        endcase
        if (w_flush) begin
            w_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            case (w_op)
                OP_IDLE: begin
                end
                OP_PUSH: begin
                    if (w_full) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_count <= r_count + CW'(1);
                    end
                end
                OP_POP: begin
                    if (w_empty) begin
                        r_underflow <= 1'b1;
                    end else begin
                        r_count <= r_count - CW'(1);
                    end
                end
                OP_REPLACE: begin
                    if (w_empty) begin
                        r_count <= CW'(1);
                    end
                end
            endcase
        end
    end

    stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (w_we),
        .waddr (w_waddr),
        .wdata (din),
        .raddr (w_raddr),
        .rdata (w_rdata)
    );

    // Popped entries stay in storage, so an empty stack must mask the read.
    assign tos       = w_empty ? '0 : w_rdata;
    assign count     = r_count;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_stack_lifo.sv
module tb_stack_lifo;

    logic        clk = 1'b0;
    logic        rst, push, pop, clr;
    logic [11:0] din;

    always #5 clk = ~clk;

    // Instance 0: 8x32, instance 1: 8x4, instance 2: 12x5 (all share stimulus).
    logic [7:0]  tos_a;  logic [5:0] cnt_a;  logic emp_a, ful_a, ovf_a, unf_a;
    logic [7:0]  tos_b;  logic [2:0] cnt_b;  logic emp_b, ful_b, ovf_b, unf_b;
    logic [11:0] tos_c;  logic [2:0] cnt_c;  logic emp_c, ful_c, ovf_c, unf_c;

    stack_lifo #(.WIDTH(8), .DEPTH(32)) dut_a (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din[7:0]), .clr(clr),
        .tos(tos_a), .count(cnt_a), .empty(emp_a), .full(ful_a),
        .overflow(ovf_a), .underflow(unf_a));

    stack_lifo #(.WIDTH(8), .DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din[7:0]), .clr(clr),
        .tos(tos_b), .count(cnt_b), .empty(emp_b), .full(ful_b),
        .overflow(ovf_b), .underflow(unf_b));

    stack_lifo #(.WIDTH(12), .DEPTH(5)) dut_c (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din), .clr(clr),
        .tos(tos_c), .count(cnt_c), .empty(emp_c), .full(ful_c),
        .overflow(ovf_c), .underflow(unf_c));

    logic [31:0] o_cnt [3];
    logic [31:0] o_tos [3];
    logic        o_emp [3];
    logic        o_ful [3];
    logic        o_ovf [3];
    logic        o_unf [3];

    assign o_cnt[0] = 32'(cnt_a);  assign o_tos[0] = 32'(tos_a);
    assign o_cnt[1] = 32'(cnt_b);  assign o_tos[1] = 32'(tos_b);
    assign o_cnt[2] = 32'(cnt_c);  assign o_tos[2] = 32'(tos_c);
    assign o_emp[0] = emp_a; assign o_ful[0] = ful_a; assign o_ovf[0] = ovf_a; assign o_unf[0] = unf_a;
    assign o_emp[1] = emp_b; assign o_ful[1] = ful_b; assign o_ovf[1] = ovf_b; assign o_unf[1] = unf_b;
    assign o_emp[2] = emp_c; assign o_ful[2] = ful_c; assign o_ovf[2] = ovf_c; assign o_unf[2] = unf_c;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic cmp(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d @%0t: actual %0h expected %0h", name, k, $time, act, exp);
        end
    endtask

    // ---------------- reference model: one plain stack per instance --------
    int dep [3] = '{32, 4, 5};
    int msk [3] = '{'hFF, 'hFF, 'hFFF};
    int stk [3][32];
    int sz  [3];
    bit m_ovf [3];
    bit m_unf [3];

    task automatic model_step(input logic r, input logic pu, input logic po,
                              input logic cl, input logic [11:0] d);
        for (int k = 0; k < 3; k++) begin
            int v;
            v = int'(d) & msk[k];
            if (r || cl) begin
                sz[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
            end else if (pu && po) begin
                // replace: pop-then-push, or a plain push when nothing to pop
                if (sz[k] > 0) stk[k][sz[k]-1] = v;
                else begin stk[k][0] = v; sz[k] = 1; end
            end else if (pu) begin
                if (sz[k] < dep[k]) begin stk[k][sz[k]] = v; sz[k]++; end
                else m_ovf[k] = 1;
            end else if (po) begin
                if (sz[k] > 0) sz[k]--;
                else m_unf[k] = 1;
            end
        end
    endtask

    task automatic check_model(input int k);
        cmp("rnd_count", k, o_cnt[k], 32'(sz[k]));
        cmp("rnd_tos",   k, o_tos[k], (sz[k] == 0) ? 32'd0 : 32'(stk[k][sz[k]-1]));
        cmp("rnd_empty", k, 32'(o_emp[k]), 32'(sz[k] == 0));
        cmp("rnd_full",  k, 32'(o_ful[k]), 32'(sz[k] == dep[k]));
        cmp("rnd_ovf",   k, 32'(o_ovf[k]), 32'(m_ovf[k]));
        cmp("rnd_unf",   k, 32'(o_unf[k]), 32'(m_unf[k]));
    endtask

    // Drive at the falling edge, let the rising edge act, sample 1 ns later.
    task automatic cycle(input logic r, input logic pu, input logic po,
                         input logic cl, input logic [11:0] d);
        @(negedge clk);
        rst = r; push = pu; pop = po; clr = cl; din = d;
        model_step(r, pu, po, cl, d);
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ---------------------------------
    typedef struct {
        logic        r, pu, po, cl;
        logic [11:0] d;
        int          k;
        int          cnt;
        int          tos;
        bit          emp, ful, ovf, unf;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic r, input logic pu, input logic po, input logic cl,
                       input logic [11:0] d, input int k, input int cnt, input int tos,
                       input bit emp, input bit ful, input bit ovf, input bit unf);
        vec_t v;
        v = '{r: r, pu: pu, po: po, cl: cl, d: d, k: k, cnt: cnt, tos: tos,
              emp: emp, ful: ful, ovf: ovf, unf: unf};
        vt.push_back(v);
    endtask

    initial begin
        rst = 1'b1; push = 1'b0; pop = 1'b0; clr = 1'b0; din = '0;
        model_step(1'b1, 1'b0, 1'b0, 1'b0, 12'h0);
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            cmp("rst_count", k, o_cnt[k], 32'd0);
            cmp("rst_tos",   k, o_tos[k], 32'd0);
            cmp("rst_empty", k, 32'(o_emp[k]), 32'd1);
            cmp("rst_full",  k, 32'(o_ful[k]), 32'd0);
            cmp("rst_ovf",   k, 32'(o_ovf[k]), 32'd0);
            cmp("rst_unf",   k, 32'(o_unf[k]), 32'd0);
        end

        //   r  pu po cl  din    k cnt tos   emp ful ovf unf
        add(0, 1, 0, 0, 12'h12, 0, 1, 'h12, 0, 0, 0, 0);
        add(0, 1, 0, 0, 12'h77, 0, 2, 'h77, 0, 0, 0, 0);
        add(0, 1, 0, 0, 12'h69, 0, 3, 'h69, 0, 0, 0, 0);
        add(0, 0, 1, 0, 12'h00, 0, 2, 'h77, 0, 0, 0, 0);
        add(0, 0, 1, 0, 12'h00, 0, 1, 'h12, 0, 0, 0, 0);
        add(0, 0, 1, 0, 12'h00, 0, 0, 'h00, 1, 0, 0, 0);
        add(0, 0, 1, 0, 12'h00, 0, 0, 'h00, 1, 0, 0, 1);
        for (int i = 0; i < 10; i++)
            add(0, 0, 0, 0, 12'h00, 0, 0, 'h00, 1, 0, 0, 1);
        add(0, 0, 0, 1, 12'h00, 0, 0, 'h00, 1, 0, 0, 0);
        add(0, 1, 0, 0, 12'h12, 0, 1, 'h12, 0, 0, 0, 0);
        add(0, 1, 1, 0, 12'h69, 0, 1, 'h69, 0, 0, 0, 0);
        add(0, 0, 0, 1, 12'h00, 0, 0, 'h00, 1, 0, 0, 0);
        add(0, 1, 1, 0, 12'h77, 0, 1, 'h77, 0, 0, 0, 0);
        add(0, 1, 0, 0, 12'h55, 0, 2, 'h55, 0, 0, 0, 0);
        add(1, 1, 0, 0, 12'h77, 0, 0, 'h00, 1, 0, 0, 0);
        // DEPTH=4 instance: fill, overfill, flush
        add(0, 1, 0, 0, 12'h01, 1, 1, 'h01, 0, 0, 0, 0);
        add(0, 1, 0, 0, 12'h02, 1, 2, 'h02, 0, 0, 0, 0);
        add(0, 1, 0, 0, 12'h03, 1, 3, 'h03, 0, 0, 0, 0);
        add(0, 1, 0, 0, 12'h04, 1, 4, 'h04, 0, 1, 0, 0);
        add(0, 1, 0, 0, 12'h05, 1, 4, 'h04, 0, 1, 1, 0);
        add(0, 0, 0, 0, 12'h00, 1, 4, 'h04, 0, 1, 1, 0);
        add(0, 0, 0, 1, 12'h00, 1, 0, 'h00, 1, 0, 0, 0);
        // DEPTH=5, 12-bit instance: replace with a full-width word
        add(0, 1, 0, 0, 12'hABC, 2, 1, 'hABC, 0, 0, 0, 0);
        add(0, 1, 1, 0, 12'hF0F, 2, 1, 'hF0F, 0, 0, 0, 0);

        foreach (vt[i]) begin
            cycle(vt[i].r, vt[i].pu, vt[i].po, vt[i].cl, vt[i].d);
            cmp("vec_count", vt[i].k, o_cnt[vt[i].k], 32'(vt[i].cnt));
            cmp("vec_tos",   vt[i].k, o_tos[vt[i].k], 32'(vt[i].tos));
            cmp("vec_empty", vt[i].k, 32'(o_emp[vt[i].k]), 32'(vt[i].emp));
            cmp("vec_full",  vt[i].k, 32'(o_ful[vt[i].k]), 32'(vt[i].ful));
            cmp("vec_ovf",   vt[i].k, 32'(o_ovf[vt[i].k]), 32'(vt[i].ovf));
            cmp("vec_unf",   vt[i].k, 32'(o_unf[vt[i].k]), 32'(vt[i].unf));
        end

        // Back-to-back: DEPTH=4 goes full and the very next push is rejected.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 12'h0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 12'(8'hA0 + i));
        cmp("b2b_full", 1, 32'(o_ful[1]), 32'd1);
        cmp("b2b_ovf_pre", 1, 32'(o_ovf[1]), 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 12'h0EE);
        cmp("b2b_ovf", 1, 32'(o_ovf[1]), 32'd1);
        cmp("b2b_tos", 1, o_tos[1], 32'h0A3);
        cmp("b2b_cnt", 1, o_cnt[1], 32'd4);

        // Randomised phase: alternating push-heavy and pop-heavy stretches.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic r, pu, po, cl;
            bit   fill;
            fill = ((cyc / 150) % 2) == 0;
            r  = ($urandom % 400) == 0;
            cl = ($urandom % 100) == 0;
            pu = ($urandom % 100) < (fill ? 75 : 30);
            po = ($urandom % 100) < (fill ? 30 : 75);
            cycle(r, pu, po, cl, 12'($urandom));
            for (int k = 0; k < 3; k++) check_model(k);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
